record_table: RTL and testbench
===============================

RECORD_TABLE -- requirements
Module: record_table

Interface
REQ-001 Parameters: DEPTH, default 8, number of records (2..256, not necessarily a power of 2).
REQ-002 Parameters: A_W, default 32, width of field a.
REQ-003 Parameters: B_W, default 16, width of field b.
REQ-004 Parameters: DEF_A, default 10, default value of field a.
REQ-005 Parameters: DEF_B, default 0, default value of field b.
REQ-006 Derived: AW = max(1, $clog2(DEPTH)), address width.
REQ-007 Clocking and reset are fixed: one clock; reset is synchronous and active-high.
REQ-008 Ports, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  pulse: restart default fill.
- ready  out  1  table initialised, accepts commands.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write index.
- wr_mask  in  2  field select: bit0 = a, bit1 = b.
- wr_a  in  A_W  write data for field a.
- wr_b  in  B_W  write data for field b.
- rd_en  in  1  read strobe.
- rd_addr  in  AW  read index.
- rd_valid  out  1  rd_a/rd_b/rd_err valid.
- rd_a  out  A_W  read data, field a.
- rd_b  out  B_W  read data, field b.
- rd_err  out  1  read address was >= DEPTH.

Function
REQ-009 Storage SHALL be an unpacked array [DEPTH] of record_t {a, b, written}; written marks any field write since the last fill.
REQ-010 FSM states SHALL be INIT and READY; reset or clr SHALL enter INIT with fill index 0.
REQ-011 INIT SHALL write '{a:DEF_A, b:DEF_B, written:0} to one entry per cycle, index 0..DEPTH-1, then enter READY; the fill takes exactly DEPTH cycles.
REQ-012 ready SHALL equal (state == READY), registered.
REQ-013 In INIT, wr_en and rd_en SHALL be ignored; rd_valid SHALL stay 0.
REQ-014 In READY, wr_en with wr_addr < DEPTH SHALL update only the fields selected in wr_mask and set written=1 when the mask is nonzero; a mask of 0 SHALL change nothing.
REQ-015 wr_addr >= DEPTH SHALL be dropped silently.
REQ-016 In READY, rd_en SHALL produce rd_valid=1 exactly one cycle later, with the stored a/b and rd_err=0; otherwise rd_valid=0 and rd_a/rd_b hold their last values.
REQ-017 rd_addr >= DEPTH SHALL return DEF_A/DEF_B with rd_err=1, one cycle later.
REQ-018 A read and a write to the same address in the same cycle SHALL return pre-write data (read-before-write).
REQ-019 clr in READY SHALL drop ready on the next cycle and refill all entries; clr in INIT SHALL restart the fill at index 0.
REQ-020 clr together with wr_en SHALL take priority: the write is discarded.
REQ-021 A read issued in the cycle clr is asserted in READY SHALL still complete with pre-clear data.
REQ-022 Debug output: written_cnt, width $clog2(DEPTH+1), SHALL count entries with written=1; it resets to 0 on fill and saturates at DEPTH.

Reset
REQ-023 On rst: state=INIT, fill index=0, ready=0, rd_valid=0, rd_a=0, rd_b=0, rd_err=0, written_cnt=0.
REQ-024 rst asserted mid-fill or mid-read SHALL abort the operation; no rd_valid pulse SHALL follow.
REQ-025 Array contents SHALL be defined only through the fill, not through reset.

Structure
REQ-026 Package record_table_pkg SHALL hold the state_e enum and the mask bit constants MASK_A=0 and MASK_B=1.
REQ-027 record_t SHALL be defined in the module because it depends on A_W and B_W.
REQ-028 No sub-module: a single module containing the FSM, array and read register.

Verification
REQ-029 DEPTH=8, release rst: ready rises 8 cycles later; reading every address returns a=10, b=0.
REQ-030 Write addr 3, mask=01, a=42, then mask=10, b=29: reading addr 3 returns a=42, b=29; addr 4 returns 10/0; written_cnt=1.
REQ-031 Same-cycle write a=5 to addr 2 and read of addr 2: rd_a=10; the next read returns 5.
REQ-032 DEPTH=5, read addr 6: rd_err=1 with 10/0; write addr 7: no entry changes.
REQ-033 clr after writes: ready low for 8 cycles, written_cnt=0, all entries back to defaults; a write during INIT is lost.
REQ-034 rst asserted at fill index 4: the fill restarts at 0, ready rises DEPTH cycles after rst deasserts, and no spurious rd_valid appears.

Source files
------------

// File: rtl/record_table_pkg.sv
// Shared types and constants for the record table.
package record_table_pkg;

   // Table controller states: filling defaults, or serving commands.
   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_e;

   // Bit positions within the write field mask.
   localparam int unsigned MASK_A = 0;
   localparam int unsigned MASK_B = 1;

endpackage : record_table_pkg

// File: rtl/record_table.sv
// Record table: DEPTH records {a, b, written} with a one-entry-per-cycle
// default fill, masked field writes and a registered read port.
module record_table
   import record_table_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned A_W   = 32,
   parameter int unsigned B_W   = 16,
   parameter int unsigned DEF_A = 10,
   parameter int unsigned DEF_B = 0,
   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr,
   output logic           ready,
   input  logic           wr_en,
   input  logic [AW-1:0]  wr_addr,
   input  logic [1:0]     wr_mask,
   input  logic [A_W-1:0] wr_a,
   input  logic [B_W-1:0] wr_b,
   input  logic           rd_en,
   input  logic [AW-1:0]  rd_addr,
   output logic           rd_valid,
   output logic [A_W-1:0] rd_a,
   output logic [B_W-1:0] rd_b,
   output logic           rd_err,
   output logic [CW-1:0]  written_cnt
);

   // One extra address bit so range checks never compare against an
   // unrepresentable DEPTH.
   localparam int unsigned AX       = AW + 1;
   localparam logic [AX-1:0] DEPTH_X  = AX'(DEPTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);

   typedef struct packed {
      logic [A_W-1:0] a;
      logic [B_W-1:0] b;
      logic           written;
   } record_t;

   localparam record_t DEF_REC = '{a: A_W'(DEF_A), b: B_W'(DEF_B), written: 1'b0};

   state_e           r_state;
   state_e           w_state_nxt;
   logic [AW-1:0]    r_fill_idx;
   logic [AW-1:0]    w_fill_nxt;
   logic             w_fill_we;
   logic             r_ready;

   record_t          r_mem [DEPTH];

   logic             w_wr_hit;
   record_t          w_wr_cur;
   record_t          w_wr_rec;
   logic             w_cnt_inc;
   logic [CW-1:0]    r_written_cnt;

   logic             w_rd_hit;
   logic             w_rd_in_range;
   record_t          w_rd_rec;
   logic             r_rd_valid;
   logic [A_W-1:0]   r_rd_a;
   logic [B_W-1:0]   r_rd_b;
   logic             r_rd_err;

   // Next-state logic: clr always restarts the fill at entry 0.
   always_comb begin
      w_state_nxt = r_state;
      w_fill_nxt  = r_fill_idx;
      w_fill_we   = 1'b0;
      if (clr) begin
         w_state_nxt = INIT;
         w_fill_nxt  = '0;
      end else begin
         case (r_state)
            INIT: begin
               w_fill_we = 1'b1;
               if (r_fill_idx == LAST_IDX) begin
                  w_state_nxt = READY;
                  w_fill_nxt  = '0;
               end else begin
                  w_fill_nxt = r_fill_idx + AW'(1);
               end
            end
            READY: begin
               w_state_nxt = READY;
            end
            default: begin
               w_state_nxt = INIT;
               w_fill_nxt  = '0;
            end
         endcase
      end
   end

   // State register; ready tracks the state it is loaded alongside.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= INIT;
         r_fill_idx <= '0;
         r_ready    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_fill_idx <= w_fill_nxt;
         r_ready    <= (w_state_nxt == READY);
      end
   end

   // Write qualification: in range, nonzero mask, not overridden by clr.
   assign w_wr_hit = (r_state == READY) && wr_en && !clr
                     && ({1'b0, wr_addr} < DEPTH_X) && (|wr_mask);
   assign w_wr_cur = r_mem[wr_addr];

   // Merge the selected fields into the current record.
   always_comb begin
      w_wr_rec = w_wr_cur;
      if (wr_mask[MASK_A]) w_wr_rec.a = wr_a;
      if (wr_mask[MASK_B]) w_wr_rec.b = wr_b;
      w_wr_rec.written = 1'b1;
   end

   // Storage: contents are defined only by the fill, never by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (w_fill_we) begin
            r_mem[r_fill_idx] <= DEF_REC;
         end else if (w_wr_hit) begin
            r_mem[wr_addr] <= w_wr_rec;
         end
      end
   end

   // Count first writes to each entry since the last fill.
   assign w_cnt_inc = w_wr_hit && !w_wr_cur.written && (r_written_cnt != CNT_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_written_cnt <= '0;
      end else if (clr || (r_state == INIT)) begin
         r_written_cnt <= '0;
      end else if (w_cnt_inc) begin
         r_written_cnt <= r_written_cnt + CW'(1);
      end
   end

   // Read port samples the array before this edge's write lands.
   assign w_rd_hit      = (r_state == READY) && rd_en;
   assign w_rd_in_range = ({1'b0, rd_addr} < DEPTH_X);
   assign w_rd_rec      = r_mem[rd_addr];

   // Registered read response; data holds between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_valid <= 1'b0;
         r_rd_a     <= '0;
         r_rd_b     <= '0;
         r_rd_err   <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_hit;
         if (w_rd_hit) begin
            if (w_rd_in_range) begin
               r_rd_a   <= w_rd_rec.a;
               r_rd_b   <= w_rd_rec.b;
               r_rd_err <= 1'b0;
            end else begin
               r_rd_a   <= A_W'(DEF_A);
               r_rd_b   <= B_W'(DEF_B);
               r_rd_err <= 1'b1;
            end
         end
      end
   end

   assign ready       = r_ready;
   assign rd_valid    = r_rd_valid;
   assign rd_a        = r_rd_a;
   assign rd_b        = r_rd_b;
   assign rd_err      = r_rd_err;
   assign written_cnt = r_written_cnt;

endmodule : record_table

// File: tb/tb_record_table.sv
// Scoreboard bench for record_table: DEPTH=8 and DEPTH=5 instances.
module tb_record_table;

   typedef struct {
      logic [31:0] a;
      logic [15:0] b;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        clr0, ready0, wr_en0, rd_en0, rd_valid0, rd_err0;
   logic [2:0]  wr_addr0, rd_addr0;
   logic [1:0]  wr_mask0;
   logic [31:0] wr_a0, rd_a0;
   logic [15:0] wr_b0, rd_b0;
   logic [3:0]  cnt0;

   logic        clr1, ready1, wr_en1, rd_en1, rd_valid1, rd_err1;
   logic [2:0]  wr_addr1, rd_addr1;
   logic [1:0]  wr_mask1;
   logic [31:0] wr_a1, rd_a1;
   logic [15:0] wr_b1, rd_b1;
   logic [2:0]  cnt1;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   n0, n1;

   record_table #(.DEPTH(8)) u_d8 (
      .clk(clk), .rst(rst), .clr(clr0), .ready(ready0),
      .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_mask(wr_mask0), .wr_a(wr_a0), .wr_b(wr_b0),
      .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_valid(rd_valid0), .rd_a(rd_a0), .rd_b(rd_b0),
      .rd_err(rd_err0), .written_cnt(cnt0)
   );

   record_table #(.DEPTH(5)) u_d5 (
      .clk(clk), .rst(rst), .clr(clr1), .ready(ready1),
      .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_mask(wr_mask1), .wr_a(wr_a1), .wr_b(wr_b1),
      .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_valid(rd_valid1), .rd_a(rd_a1), .rd_b(rd_b1),
      .rd_err(rd_err1), .written_cnt(cnt1)
   );

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   // Monitors: every rd_valid must match the oldest expected response.
   always @(negedge clk) begin
      if (rd_valid0) begin
         if (q0.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rd0_spurious: got rd_valid=1, expected 0 (a=%0d)", rd_a0);
         end else begin
            e0 = q0.pop_front();
            chk("rd0_a", 64'(rd_a0), 64'(e0.a));
            chk("rd0_b", 64'(rd_b0), 64'(e0.b));
            chk("rd0_err", 64'(rd_err0), 64'(e0.err));
         end
      end
   end

   always @(negedge clk) begin
      if (rd_valid1) begin
         if (q1.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rd1_spurious: got rd_valid=1, expected 0 (a=%0d)", rd_a1);
         end else begin
            e1 = q1.pop_front();
            chk("rd1_a", 64'(rd_a1), 64'(e1.a));
            chk("rd1_b", 64'(rd_b1), 64'(e1.b));
            chk("rd1_err", 64'(rd_err1), 64'(e1.err));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd0(input logic [2:0] addr, input logic [31:0] ea, input logic [15:0] eb, input logic ee);
      rd_en0   = 1'b1;
      rd_addr0 = addr;
      q0.push_back('{a: ea, b: eb, err: ee});
      tick();
      rd_en0 = 1'b0;
   endtask

   task automatic rd1(input logic [2:0] addr, input logic [31:0] ea, input logic [15:0] eb, input logic ee);
      rd_en1   = 1'b1;
      rd_addr1 = addr;
      q1.push_back('{a: ea, b: eb, err: ee});
      tick();
      rd_en1 = 1'b0;
   endtask

   task automatic wr0(input logic [2:0] addr, input logic [1:0] mask, input logic [31:0] a, input logic [15:0] b);
      wr_en0 = 1'b1; wr_addr0 = addr; wr_mask0 = mask; wr_a0 = a; wr_b0 = b;
      tick();
      wr_en0 = 1'b0;
   endtask

   task automatic wr1(input logic [2:0] addr, input logic [1:0] mask, input logic [31:0] a, input logic [15:0] b);
      wr_en1 = 1'b1; wr_addr1 = addr; wr_mask1 = mask; wr_a1 = a; wr_b1 = b;
      tick();
      wr_en1 = 1'b0;
   endtask

   // Count cycles until ready rises; commands held during the fill must be ignored.
   task automatic wait_ready(input int sel, input string name, input int exp_n);
      int n;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if ((sel == 0 && ready0) || (sel == 1 && ready1)) begin
            n = i;
            break;
         end
      end
      rd_en0 = 1'b0; wr_en0 = 1'b0;
      rd_en1 = 1'b0; wr_en1 = 1'b0;
      chk(name, 64'(n), 64'(exp_n));
   endtask

   initial begin
      rst = 1'b1;
      clr0 = 1'b0; wr_en0 = 1'b0; rd_en0 = 1'b0; wr_addr0 = '0; rd_addr0 = '0;
      wr_mask0 = '0; wr_a0 = '0; wr_b0 = '0;
      clr1 = 1'b0; wr_en1 = 1'b0; rd_en1 = 1'b0; wr_addr1 = '0; rd_addr1 = '0;
      wr_mask1 = '0; wr_a1 = '0; wr_b1 = '0;
      tick();
      tick();
      chk("rst_ready0", 64'(ready0), 64'd0);
      chk("rst_rd_valid0", 64'(rd_valid0), 64'd0);
      chk("rst_rd_a0", 64'(rd_a0), 64'd0);
      chk("rst_cnt0", 64'(cnt0), 64'd0);
      chk("rst_ready1", 64'(ready1), 64'd0);

      // Initial fill; a write and a read held during INIT are dropped.
      rst = 1'b0;
      rd_en0 = 1'b1; rd_addr0 = 3'd1;
      wr_en0 = 1'b1; wr_addr0 = 3'd1; wr_mask0 = 2'b11; wr_a0 = 77; wr_b0 = 77;
      n0 = 0; n1 = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (ready1 && n1 == 0) n1 = i;
         if (ready0 && n0 == 0) begin
            n0 = i;
            rd_en0 = 1'b0;
            wr_en0 = 1'b0;
         end
         if (n0 != 0) break;
      end
      rd_en0 = 1'b0; wr_en0 = 1'b0;
      chk("fill_cycles0", 64'(n0), 64'd8);
      chk("fill_cycles1", 64'(n1), 64'd5);

      for (int i = 0; i < 8; i++) rd0(3'(i), 32'd10, 16'd0, 1'b0);

      // Masked field writes to entry 3.
      wr0(3'd3, 2'b01, 32'd42, 16'd7);
      wr0(3'd3, 2'b10, 32'd99, 16'd29);
      chk("cnt0_after_addr3", 64'(cnt0), 64'd1);
      rd0(3'd3, 32'd42, 16'd29, 1'b0);
      rd0(3'd4, 32'd10, 16'd0, 1'b0);

      // Same-cycle read and write: read returns old data.
      wr_en0 = 1'b1; wr_addr0 = 3'd2; wr_mask0 = 2'b01; wr_a0 = 32'd5; wr_b0 = 16'd9;
      rd_en0 = 1'b1; rd_addr0 = 3'd2;
      q0.push_back('{a: 32'd10, b: 16'd0, err: 1'b0});
      tick();
      wr_en0 = 1'b0; rd_en0 = 1'b0;
      rd0(3'd2, 32'd5, 16'd0, 1'b0);

      // Zero mask changes nothing.
      wr0(3'd5, 2'b00, 32'd55, 16'd55);
      chk("cnt0_after_mask0", 64'(cnt0), 64'd2);
      rd0(3'd5, 32'd10, 16'd0, 1'b0);

      // DEPTH=5: out-of-range read and dropped write.
      rd1(3'd6, 32'd10, 16'd0, 1'b1);
      wr1(3'd7, 2'b11, 32'd77, 16'd77);
      for (int i = 0; i < 5; i++) rd1(3'(i), 32'd10, 16'd0, 1'b0);
      chk("cnt1_oob_write", 64'(cnt1), 64'd0);

      // clr mid-fill restarts from entry 0.
      clr1 = 1'b1; tick(); clr1 = 1'b0;
      tick(); tick();
      clr1 = 1'b1; tick(); clr1 = 1'b0;
      wait_ready(1, "clr_restart1", 5);
      tick(); tick();

      // clr with a concurrent write and read in READY.
      clr0 = 1'b1;
      wr_en0 = 1'b1; wr_addr0 = 3'd6; wr_mask0 = 2'b01; wr_a0 = 32'd123;
      rd_en0 = 1'b1; rd_addr0 = 3'd3;
      q0.push_back('{a: 32'd42, b: 16'd29, err: 1'b0});
      tick();
      clr0 = 1'b0; wr_en0 = 1'b0; rd_en0 = 1'b0;
      chk("clr_ready0", 64'(ready0), 64'd0);
      chk("clr_cnt0", 64'(cnt0), 64'd0);
      wr_en0 = 1'b1; wr_addr0 = 3'd0; wr_mask0 = 2'b11; wr_a0 = 32'd88; wr_b0 = 16'd88;
      rd_en0 = 1'b1; rd_addr0 = 3'd0;
      wait_ready(0, "clr_fill0", 8);
      for (int i = 0; i < 8; i++) rd0(3'(i), 32'd10, 16'd0, 1'b0);
      chk("clr_cnt0_after", 64'(cnt0), 64'd0);
      tick(); tick();

      // rst during a read, then again at fill index 4.
      rst = 1'b1; rd_en0 = 1'b1; rd_addr0 = 3'd3;
      tick();
      rst = 1'b0; rd_en0 = 1'b0;
      chk("rst_read_ready0", 64'(ready0), 64'd0);
      chk("rst_read_valid0", 64'(rd_valid0), 64'd0);
      chk("rst_read_a0", 64'(rd_a0), 64'd0);
      chk("rst_read_b0", 64'(rd_b0), 64'd0);
      repeat (4) tick();
      chk("midfill_ready0", 64'(ready0), 64'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rd_en0 = 1'b1; rd_addr0 = 3'd1;
      wait_ready(0, "rst_fill0", 8);
      wr0(3'd1, 2'b11, 32'd1, 16'd2);
      rd0(3'd1, 32'd1, 16'd2, 1'b0);
      rd0(3'd3, 32'd10, 16'd0, 1'b0);
      chk("cnt0_final", 64'(cnt0), 64'd1);

      repeat (3) tick();
      chk("q0_drained", 64'(q0.size()), 64'd0);
      chk("q1_drained", 64'(q1.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_record_table
